// File: rtl/scan_shift_ctrl.sv
// Scan shift controller: serially loads a parallel pattern into a CDR scan
// chain, pulses one capture cycle, unloads the response, and compares it
// against a masked expected value.
module scan_shift_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 7
) (
  input  logic                 CLK,
  input  logic                 CoreIN_RESET,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expect_in,
  input  logic [CHAIN_LEN-1:0] mask_in,
  input  logic                 ScanChainOut,
  output logic                 ScanChainIN,
  output logic                 se,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response_out,
  output logic [15:0]          pattern_cnt
);

  // Index width for selecting one pattern bit; never wider than the counter.
  localparam int IW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t               state, nextState;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cntInc;
  logic [CHAIN_LEN-1:0] patReg, expReg, maskReg;
  logic [CHAIN_LEN-1:0] respNext;
  logic                 accept, lastCnt, finishOut;
  logic                 seNext, sinNext;

  assign cntInc    = cnt + CNT_W'(1);
  assign lastCnt   = (cnt == TERM_CNT);
  assign accept    = (state == IDLE) && start;
  assign finishOut = (state == SHIFT_OUT) && lastCnt;
  // Right shift: first sampled bit ends up in bit 0 after CHAIN_LEN samples.
  assign respNext  = {ScanChainOut, response_out[CHAIN_LEN-1:1]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge CLK or posedge CoreIN_RESET) begin
    if (CoreIN_RESET) state <= IDLE;
    else              state <= nextState;
  end

  // Next-state logic plus the next values of the registered chain controls.
  // se/ScanChainIN are registered from next state so they line up exactly
  // with the state they belong to, without a combinational path to the chain.
  always_comb begin
    nextState = state;
    seNext    = 1'b0;
    sinNext   = 1'b0;
    case (state)
      IDLE:      if (start)   nextState = SHIFT_IN;
      SHIFT_IN:  if (lastCnt) nextState = CAPTURE;
      CAPTURE:                nextState = SHIFT_OUT;
      SHIFT_OUT: if (lastCnt) nextState = DONE;
      DONE:                   nextState = IDLE;
      default:                nextState = IDLE;
    endcase
    seNext = (nextState == SHIFT_IN) || (nextState == SHIFT_OUT);
    if (accept)
      sinNext = pattern_in[0];
    else if ((state == SHIFT_IN) && !lastCnt)
      sinNext = patReg[cntInc[IW-1:0]];
  end

  // Shift counter: runs 0..N-1 in the two shift states, parked at 0 elsewhere.
  always_ff @(posedge CLK or posedge CoreIN_RESET) begin
    if (CoreIN_RESET)
      cnt <= '0;
    else if (((state == SHIFT_IN) || (state == SHIFT_OUT)) && !lastCnt)
      cnt <= cntInc;
    else
      cnt <= '0;
  end

  // Operand latches: captured only on acceptance, untouched while busy.
  always_ff @(posedge CLK or posedge CoreIN_RESET) begin
    if (CoreIN_RESET) begin
      patReg  <= '0;
      expReg  <= '0;
      maskReg <= '0;
    end else if (accept) begin
      patReg  <= pattern_in;
      expReg  <= expect_in;
      maskReg <= mask_in;
    end
  end

  // Registered chain controls.
  always_ff @(posedge CLK or posedge CoreIN_RESET) begin
    if (CoreIN_RESET) begin
      se          <= 1'b0;
      ScanChainIN <= 1'b0;
    end else begin
      se          <= seNext;
      ScanChainIN <= sinNext;
    end
  end

  // Response unload, compare result and saturating pattern counter.
  always_ff @(posedge CLK or posedge CoreIN_RESET) begin
    if (CoreIN_RESET) begin
      response_out <= '0;
      pass         <= 1'b0;
      pattern_cnt  <= '0;
    end else begin
      if (state == SHIFT_OUT)
        response_out <= respNext;
      if (accept)
        pass <= 1'b0;
      else if (finishOut)
        pass <= (((respNext ^ expReg) & ~maskReg) == '0);
      if (finishOut && (pattern_cnt != 16'hFFFF))
        pattern_cnt <= pattern_cnt + 16'd1;
    end
  end

endmodule
